// File: rtl/register_state_param_pkg.sv
// Shared types and defaults for the parametrised Ascon permutation state register.
// Holds the update-mode encoding, the default geometry, the fixed-geometry state type
// and a helper that flags the two reserved mode encodings.
package register_state_param_pkg;

  localparam int DEF_NB_WORDS = 5;
  localparam int DEF_WORD_W   = 64;
  localparam int DEF_KEY_W    = 128;

  typedef enum logic [2:0] {
    HOLD         = 3'b000,
    LOAD         = 3'b001,
    XOR_LANE     = 3'b010,
    XOR_KEY_TAIL = 3'b011,
    XOR_KEY_HEAD = 3'b100,
    XOR_DOMAIN   = 3'b101
  } mode_e;

  // One lane and the state array for the default 5x64 geometry. The top level
  // declares the same shape locally from its NB_WORDS/WORD_W parameters.
  typedef logic [DEF_WORD_W-1:0] type_lane;
  typedef type_lane type_state [DEF_NB_WORDS];

  // 110 and 111 are reserved encodings.
  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= 3'b101);
  endfunction

endpackage

// File: rtl/register_state_param_state_lane_reg.sv
// One WORD_W-bit lane register with synchronous active-low reset and load enable.
// Latency: d is visible on q one cycle after an enabled edge. No backpressure.
// Ports: clk, resetb (sync, active-low), en (load enable), d (next value), q (lane).
module state_lane_reg
  import register_state_param_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              en,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_state_param.sv
// Ascon permutation state register with in-place update modes, one-entry snapshot
// shadow, saturating update counter and error pulse. Latency: every update, snapshot
// or restore shows on the outputs one cycle after the sampling edge. No backpressure:
// a request can be issued every cycle; illegal requests hold the state.
// Ports: clock_i, resetb_i (sync, active-low); en_i/mode_i select the update;
// register_i (LOAD operand, lane 0 in the MSBs), lane_sel_i/data_i (XOR_LANE operand),
// key_i (key XOR operand); snap_i/restore_i drive the shadow;
// register_o (state, straight from flops), snap_valid_o, upd_cnt_o, err_o.
module register_state_param
  import register_state_param_pkg::*;
#(
  parameter int NB_WORDS = DEF_NB_WORDS,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int KEY_W    = DEF_KEY_W
) (
  input  logic                         clock_i,
  input  logic                         resetb_i,
  input  logic                         en_i,
  input  logic [2:0]                   mode_i,
  input  logic [NB_WORDS*WORD_W-1:0]   register_i,
  input  logic [$clog2(NB_WORDS)-1:0]  lane_sel_i,
  input  logic [WORD_W-1:0]            data_i,
  input  logic [KEY_W-1:0]             key_i,
  input  logic                         snap_i,
  input  logic                         restore_i,
  output logic [NB_WORDS*WORD_W-1:0]   register_o,
  output logic                         snap_valid_o,
  output logic [15:0]                  upd_cnt_o,
  output logic                         err_o
);

  localparam int KW    = KEY_W / WORD_W;
  localparam int SEL_W = $clog2(NB_WORDS);

  typedef logic [WORD_W-1:0] lane_t;

  lane_t       state_q  [NB_WORDS];
  lane_t       state_d  [NB_WORDS];
  lane_t       shadow_q [NB_WORDS];
  logic        snap_valid;
  logic [15:0] upd_cnt;
  logic        err_q;

  mode_e mode;
  logic  restore_ok;
  logic  restore_bad;
  logic  mode_bad;
  logic  sel_bad;
  logic  upd_go;
  logic  err_d;
  logic  state_en;

  assign mode        = mode_e'(mode_i);
  assign restore_ok  = restore_i & snap_valid;
  assign restore_bad = restore_i & ~snap_valid;
  assign mode_bad    = en_i & ~mode_legal(mode_i);
  // Only reachable when NB_WORDS is not a power of two.
  assign sel_bad     = en_i & (mode_i == XOR_LANE) &
                       ({1'b0, lane_sel_i} >= (SEL_W+1)'(NB_WORDS));

  // An invalid restore turns the whole cycle into HOLD, so any restore_i
  // blocks the mode path: a valid one wins, an invalid one is an error.
  assign upd_go   = en_i & ~restore_i & ~mode_bad & ~sel_bad & (mode_i != HOLD);
  assign state_en = restore_ok | upd_go;

  // A valid restore overrides the mode, so a bad mode alongside it is not reported.
  assign err_d = restore_bad | (~restore_ok & (mode_bad | sel_bad));

  always_comb begin
    for (int i = 0; i < NB_WORDS; i++) begin
      state_d[i] = state_q[i];
    end
    if (restore_ok) begin
      for (int i = 0; i < NB_WORDS; i++) begin
        state_d[i] = shadow_q[i];
      end
    end else if (upd_go) begin
      case (mode)
        LOAD: begin
          for (int i = 0; i < NB_WORDS; i++) begin
            state_d[i] = register_i[(NB_WORDS-i)*WORD_W-1 -: WORD_W];
          end
        end
        XOR_LANE: begin
          state_d[lane_sel_i] = state_q[lane_sel_i] ^ data_i;
        end
        // Key MSB word lands on the lowest-index target lane.
        XOR_KEY_TAIL: begin
          for (int k = 0; k < KW; k++) begin
            state_d[NB_WORDS-KW+k] = state_q[NB_WORDS-KW+k] ^
                                     key_i[KEY_W-1-k*WORD_W -: WORD_W];
          end
        end
        XOR_KEY_HEAD: begin
          for (int k = 0; k < KW; k++) begin
            state_d[1+k] = state_q[1+k] ^ key_i[KEY_W-1-k*WORD_W -: WORD_W];
          end
        end
        XOR_DOMAIN: begin
          state_d[NB_WORDS-1][0] = ~state_q[NB_WORDS-1][0];
        end
        default: begin
        end
      endcase
    end
  end

  // Shadow always captures the pre-edge state, which makes snap+restore a swap.
  for (genvar g = 0; g < NB_WORDS; g++) begin : g_lane
    state_lane_reg #(.WORD_W(WORD_W)) u_state (
      .clk    (clock_i),
      .resetb (resetb_i),
      .en     (state_en),
      .d      (state_d[g]),
      .q      (state_q[g])
    );

    state_lane_reg #(.WORD_W(WORD_W)) u_shadow (
      .clk    (clock_i),
      .resetb (resetb_i),
      .en     (snap_i),
      .d      (state_q[g]),
      .q      (shadow_q[g])
    );

    assign register_o[(NB_WORDS-g)*WORD_W-1 -: WORD_W] = state_q[g];
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      snap_valid <= 1'b0;
      upd_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (snap_i) begin
        snap_valid <= 1'b1;
      end
      if (upd_go && (upd_cnt != 16'hFFFF)) begin
        upd_cnt <= upd_cnt + 16'd1;
      end
      err_q <= err_d;
    end
  end

  assign snap_valid_o = snap_valid;
  assign upd_cnt_o    = upd_cnt;
  assign err_o        = err_q;

endmodule

// File: tb/tb_register_state_param.sv
module tb_register_state_param;

  logic         clk = 1'b0;
  logic         rstb;
  logic         en;
  logic [2:0]   mode;
  logic [319:0] reg_in;
  logic [2:0]   sel;
  logic [63:0]  data;
  logic [127:0] key;
  logic         snap;
  logic         restore;
  logic [319:0] reg_out;
  logic         snap_valid;
  logic [15:0]  upd_cnt;
  logic         err;

  always #5 clk = ~clk;

  register_state_param dut (
    .clock_i      (clk),
    .resetb_i     (rstb),
    .en_i         (en),
    .mode_i       (mode),
    .register_i   (reg_in),
    .lane_sel_i   (sel),
    .data_i       (data),
    .key_i        (key),
    .snap_i       (snap),
    .restore_i    (restore),
    .register_o   (reg_out),
    .snap_valid_o (snap_valid),
    .upd_cnt_o    (upd_cnt),
    .err_o        (err)
  );

  typedef struct {
    logic [319:0] r;
    logic [15:0]  c;
    logic         sv;
    logic         e;
    string        name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [63:0]  K0 = 64'h0001020304050607;
  localparam logic [63:0]  K1 = 64'h08090A0B0C0D0E0F;
  localparam logic [319:0] S1 = {64'h80400C0600000000, 64'd1, 64'd2, 64'd3, 64'd4};
  localparam logic [319:0] SK = {64'd0, K0, K1, K0, K1};
  localparam logic [319:0] PA = {5{64'h1111111111111111}};
  localparam logic [319:0] PB = {5{64'h2222222222222222}};
  localparam logic [319:0] PC = {5{64'h3333333333333333}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [319:0] r, input logic [15:0] c,
                      input logic sv, input logic e, input string name);
    exp_t x;
    x.r = r; x.c = c; x.sv = sv; x.e = e; x.name = name;
    q.push_back(x);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (reg_out !== x.r) begin
          bad++;
          $display("FAIL %s register_o got %h want %h", x.name, reg_out, x.r);
        end
        total++;
        if (upd_cnt !== x.c) begin
          bad++;
          $display("FAIL %s upd_cnt_o got %h want %h", x.name, upd_cnt, x.c);
        end
        total++;
        if (snap_valid !== x.sv) begin
          bad++;
          $display("FAIL %s snap_valid_o got %b want %b", x.name, snap_valid, x.sv);
        end
        total++;
        if (err !== x.e) begin
          bad++;
          $display("FAIL %s err_o got %b want %b", x.name, err, x.e);
        end
      end
    end
  end

  initial begin
    // Reset for two cycles with busy inputs that must be ignored.
    rstb = 1'b0; en = 1'b1; mode = 3'b001; reg_in = S1; sel = 3'd0;
    data = 64'd0; key = {K0, K1}; snap = 1'b1; restore = 1'b1;
    tick(); tick();
    push('0, 16'd0, 1'b0, 1'b0, "reset");

    // LOAD then XOR_LANE
    rstb = 1'b1; snap = 1'b0; restore = 1'b0;
    en = 1'b1; mode = 3'b001; reg_in = S1;
    tick(); push(S1, 16'd1, 1'b0, 1'b0, "load");
    mode = 3'b010; sel = 3'd0; data = 64'h1;
    tick(); push({64'h80400C0600000001, 64'd1, 64'd2, 64'd3, 64'd4}, 16'd2, 1'b0, 1'b0, "xor_lane");

    // Key XORs from the all-zero state
    mode = 3'b001; reg_in = '0;
    tick(); push('0, 16'd3, 1'b0, 1'b0, "load_zero");
    mode = 3'b011;
    tick(); push({64'd0, 64'd0, 64'd0, K0, K1}, 16'd4, 1'b0, 1'b0, "key_tail");
    mode = 3'b100;
    tick(); push(SK, 16'd5, 1'b0, 1'b0, "key_head");

    // Domain flip twice
    mode = 3'b101;
    tick(); push({64'd0, K0, K1, K0, 64'h08090A0B0C0D0E0E}, 16'd6, 1'b0, 1'b0, "domain1");
    tick(); push(SK, 16'd7, 1'b0, 1'b0, "domain2");

    // Illegal mode, then error clears
    mode = 3'b110;
    tick(); push(SK, 16'd7, 1'b0, 1'b1, "mode110");
    en = 1'b0;
    tick(); push(SK, 16'd7, 1'b0, 1'b0, "err_clear1");

    // Out-of-range lane, back-to-back errors keep err_o high
    en = 1'b1; mode = 3'b010; sel = 3'd5; data = 64'hFFFF;
    tick(); push(SK, 16'd7, 1'b0, 1'b1, "sel5");
    sel = 3'd7;
    tick(); push(SK, 16'd7, 1'b0, 1'b1, "sel7_b2b");
    en = 1'b0;
    tick(); push(SK, 16'd7, 1'b0, 1'b0, "err_clear2");

    // Restore without a snapshot: held even with a LOAD present
    en = 1'b1; mode = 3'b001; reg_in = PC; restore = 1'b1;
    tick(); push(SK, 16'd7, 1'b0, 1'b1, "restore_nosnap");

    // Snapshot, three LOADs, restore (beats a LOAD in the same cycle)
    en = 1'b0; restore = 1'b0; snap = 1'b1;
    tick(); push(SK, 16'd7, 1'b1, 1'b0, "snap");
    snap = 1'b0; en = 1'b1; mode = 3'b001;
    reg_in = PA; tick(); push(PA, 16'd8, 1'b1, 1'b0, "load_a");
    reg_in = PB; tick(); push(PB, 16'd9, 1'b1, 1'b0, "load_b");
    reg_in = PC; tick(); push(PC, 16'd10, 1'b1, 1'b0, "load_c");
    restore = 1'b1; reg_in = PA;
    tick(); push(SK, 16'd10, 1'b1, 1'b0, "restore");

    // Snap + restore in one cycle swaps state and shadow
    restore = 1'b0; reg_in = PA;
    tick(); push(PA, 16'd11, 1'b1, 1'b0, "load_a2");
    en = 1'b0; snap = 1'b1; restore = 1'b1;
    tick(); push(SK, 16'd11, 1'b1, 1'b0, "swap");
    snap = 1'b0;
    tick(); push(PA, 16'd11, 1'b1, 1'b0, "swap_back");

    // Counter saturation: 65540 domain flips from reset (even count -> state zero)
    rstb = 1'b0; restore = 1'b0; en = 1'b0;
    tick();
    rstb = 1'b1; en = 1'b1; mode = 3'b101;
    for (int i = 0; i < 65534; i++) tick();
    push('0, 16'hFFFE, 1'b0, 1'b0, "cnt_fffe");
    for (int i = 0; i < 6; i++) tick();
    push('0, 16'hFFFF, 1'b0, 1'b0, "cnt_sat");

    // Reset wins over LOAD + snap in the same cycle
    rstb = 1'b0; mode = 3'b001; reg_in = S1; snap = 1'b1;
    tick(); push('0, 16'd0, 1'b0, 1'b0, "rst_prec");
    rstb = 1'b1; en = 1'b0; snap = 1'b0; restore = 1'b1;
    tick(); push('0, 16'd0, 1'b0, 1'b1, "restore_after_rst");
    restore = 1'b0;
    tick(); push('0, 16'd0, 1'b0, 1'b0, "err_clear3");

    tick(); tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
